// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types and sizing helpers for the adder-share scheduler
// Purpose: FSM state encoding plus derived-width helpers used by the scheduler
//          and its arbiter.
// Ports:   none (package).
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full operand width of a multi-limb request.
  function automatic int opw(input int width, input int limbs);
    return width * limbs;
  endfunction

  // Index width for n items; never below one bit so a single item still has a field.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
// Purpose: grant the first asserted request at or after ptr, wrapping at N.
// Ports:   req   in  N   request vector
//          ptr   in  IW  starting index (must be < N)
//          grant out N   one-hot grant, zero when no request is asserted
//          idx   out IW  encoded index of the grant (0 when none)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin scheduler sharing one limb adder among requesters
// Purpose: accepts one multi-limb add at a time, feeds it through an external
//          combinational WIDTH-bit adder one limb per cycle (LS limb first, carry
//          chained), then presents the full result until it is accepted.
// Ports:   clk, rst (async, active-high)
//          req_valid/req_ready/req_a/req_b/req_cin  per-requester request side
//          add_a/add_b/add_cin -> shared adder; add_sum/add_cout/add_ovf <- shared adder
//          rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout/rsp_ovf  result side
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int LIMBS = 4,
  localparam int OPW  = opw(WIDTH, LIMBS),
  localparam int ID_W = id_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  input  logic                 add_ovf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [OPW-1:0]       rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf
);

  localparam int CNT_W = id_w(LIMBS);

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   g_idx;
  logic [NREQ-1:0]   grant;
  logic [CNT_W-1:0]  cnt;
  logic [OPW-1:0]    op_a, op_b;
  logic              carry;
  logic              last_limb;

  rr_arbiter #(.N(NREQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (g_idx)
  );

  assign last_limb = (cnt == CNT_W'(LIMBS - 1));

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Held off while rst is asserted so no requester sees an accept during reset.
        if (!rst) req_ready = grant;
        if (|grant) state_nx = RUN;
      end
      RUN: begin
        add_a   = op_a[cnt*WIDTH +: WIDTH];
        add_b   = op_b[cnt*WIDTH +: WIDTH];
        add_cin = carry;
        if (last_limb) state_nx = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (|grant) begin
            op_a   <= req_a[g_idx*OPW +: OPW];
            op_b   <= req_b[g_idx*OPW +: OPW];
            carry  <= req_cin[g_idx];
            rsp_id <= g_idx;
            cnt    <= '0;
            ptr    <= (g_idx == ID_W'(NREQ - 1)) ? '0 : g_idx + 1'b1;
          end
        end
        RUN: begin
          rsp_sum[cnt*WIDTH +: WIDTH] <= add_sum;
          carry <= add_cout;
          cnt   <= cnt + 1'b1;
          // Only the top limb's carry/overflow describe the full-width add.
          if (last_limb) begin
            rsp_cout <= add_cout;
            rsp_ovf  <= add_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
